// File: rtl/data_mem_ctrl.sv
// Memory-stage data-access controller.
// Sequences one load/store at a time into a fixed-latency single-port word RAM.
// The pipeline is stalled until the access completes. The block also does RV32I
// byte/half/word lane steering for stores and sign/zero extension for loads.
module data_mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    output logic              access_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ld_q, ld_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [3:0]        ram_be_q, ram_be_d;
    logic [ADDR_W-3:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic              req;
    logic              req_ok;
    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] ld_shift;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;
    logic              stall_c;
    logic              err_c;

    // A store wins over a simultaneous load, so mem_wr alone selects the op type.
    assign req = mem_rd | mem_wr;

    // Legality: the funct3 must exist for the op, and the address must be naturally aligned.
    always_comb begin
        req_ok = 1'b0;
        if (mem_wr) begin
            case (funct3)
                3'b000:  req_ok = 1'b1;
                3'b001:  req_ok = ~addr[0];
                3'b010:  req_ok = (addr[1:0] == 2'b00);
                default: req_ok = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b100: req_ok = 1'b1;
                3'b001, 3'b101: req_ok = ~addr[0];
                3'b010:         req_ok = (addr[1:0] == 2'b00);
                default:        req_ok = 1'b0;
            endcase
        end
    end

    // Byte-lane mask and replicated store data for the requested access size.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = wr_data;
        case (funct3[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << addr[1:0];
                lane_wdata = {4{wr_data[7:0]}};
            end
            2'b01: begin
                lane_be    = addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wr_data[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = wr_data;
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        ld_shift = ram_rdata >> {off_q, 3'b000};
        ld_half  = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = ram_rdata;
        endcase
    end

    // FSM next-state, RAM command generation and load capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_d        = ld_q;
        f3_d        = f3_q;
        off_d       = off_q;
        rd_data_d   = rd_data_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_be_d    = 4'b0000;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        stall_c     = 1'b0;
        err_c       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (req_ok) begin
                        stall_c     = 1'b1;
                        state_d     = S_ISSUE;
                        ld_d        = ~mem_wr;
                        f3_d        = funct3;
                        off_d       = addr[1:0];
                        ram_en_d    = 1'b1;
                        ram_we_d    = mem_wr;
                        ram_be_d    = lane_be;
                        ram_addr_d  = addr[ADDR_W-1:2];
                        ram_wdata_d = mem_wr ? lane_wdata : '0;
                    end else begin
                        // Rejected in place: no RAM access, the core is not held.
                        err_c = 1'b1;
                        if (!mem_wr) rd_data_d = '0;
                    end
                end
            end
            S_ISSUE: begin
                stall_c = 1'b1;
                cnt_d   = WAIT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                stall_c = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (ld_q) rd_data_d = ld_ext;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            ld_q        <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            rd_data_q   <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= 4'b0000;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_q        <= ld_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            rd_data_q   <= rd_data_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_be_q    <= ram_be_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Combinational outputs are forced low while reset is held so every output reads 0.
    assign stall      = reset & stall_c;
    assign access_err = reset & err_c;
    assign rd_data    = rd_data_q;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_be     = ram_be_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;

endmodule
